// File: rtl/key_debounce_if.sv
// Key-side signal bundle for key_debounce: raw key in, conditioned level/strobes/count out.
// Strobes are single-cycle and carry no back-pressure; the consumer must sample every cycle.
interface key_debounce_if;
    logic       key_n;
    logic       btn;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_cnt;
    logic [1:0] dbg_state;

    modport master (
        output key_n,
        input  btn,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  press_cnt,
        input  dbg_state
    );

    modport slave (
        input  key_n,
        output btn,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output press_cnt,
        output dbg_state
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, 4-state debounce FSM, press/release strobes,
// wrapping press counter. Long-press strobe is built only when KEY_LONGPRESS_EN is defined.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic          clk,
    input  logic          reset,
    key_debounce_if.slave kif
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             raw;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q, btn_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic [7:0]       press_cnt_q, press_cnt_d;

    // Synchronizer flops idle at 1 so reset looks like a released key.
    assign sync1_d = kif.key_n;
    assign sync2_d = sync1_q;
    assign raw     = ~sync2_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        btn_d           = btn_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        press_cnt_d     = press_cnt_q;
        case (state_q)
            IDLE: begin
                if (raw) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!raw) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = HELD;
                    btn_d         = 1'b1;
                    press_pulse_d = 1'b1;
                    press_cnt_d   = press_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!raw) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                // Returning to HELD is a rejected release bounce, so no new press strobe.
                if (raw) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = IDLE;
                    btn_d           = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            state_q         <= IDLE;
            cnt_q           <= '0;
            btn_q           <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            press_cnt_q     <= 8'd0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            btn_q           <= btn_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            press_cnt_q     <= press_cnt_d;
        end
    end

    assign kif.btn           = btn_q;
    assign kif.press_pulse   = press_pulse_q;
    assign kif.release_pulse = release_pulse_q;
    assign kif.press_cnt     = press_cnt_q;
    assign kif.dbg_state     = state_q;

`ifdef KEY_LONGPRESS_EN
    localparam int unsigned       LONG_W    = $clog2(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_done_q, long_done_d;
    logic              long_pulse_q, long_pulse_d;

    // Counter saturates at its last value; long_done keeps the strobe to one per press.
    always_comb begin
        long_cnt_d   = long_cnt_q;
        long_done_d  = long_done_q;
        long_pulse_d = 1'b0;
        if (state_q == HELD || state_q == REL_CHK) begin
            if (long_cnt_q != LONG_LAST) begin
                long_cnt_d = long_cnt_q + LONG_W'(1);
            end else if (!long_done_q) begin
                long_pulse_d = 1'b1;
                long_done_d  = 1'b1;
            end
        end else begin
            long_cnt_d  = '0;
            long_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            long_cnt_q   <= '0;
            long_done_q  <= 1'b0;
            long_pulse_q <= 1'b0;
        end else begin
            long_cnt_q   <= long_cnt_d;
            long_done_q  <= long_done_d;
            long_pulse_q <= long_pulse_d;
        end
    end

    assign kif.long_pulse = long_pulse_q;
`else
    assign kif.long_pulse = 1'b0;
`endif

endmodule
